// File: rtl/decode_skid_stage.sv
// IF->ID stage: accepts instruction/PC from fetch, classifies the opcode into
// the one-hot immediate format vector, and presents a registered decode bundle.
// A main slot drives the outputs; a skid slot absorbs the one extra beat that
// can arrive while the ready signal is still registered high.
module decode_skid_stage #(
    parameter logic [31:0] RESET_INST = 32'h00000013,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [5:0]  o_format,
    output logic        o_illegal
);

    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

    // Returns {illegal, format}. Unknown opcodes (including compressed
    // encodings, low bits != 2'b11) report illegal with the R bit set so the
    // format stays one-hot.
    function automatic logic [6:0] decode_fmt(input logic [6:0] opcode);
        logic [6:0] res;
        res = {1'b1, FMT_R};
        case (opcode)
            7'b0110011: res = {1'b0, FMT_R};
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011,
            7'b0001111: res = {1'b0, FMT_I};
            7'b0100011: res = {1'b0, FMT_S};
            7'b1100011: res = {1'b0, FMT_B};
            7'b0110111,
            7'b0010111: res = {1'b0, FMT_U};
            7'b1101111: res = {1'b0, FMT_J};
            default:    res = {1'b1, FMT_R};
        endcase
        return res;
    endfunction

    logic        main_valid_q, main_valid_d;
    logic [31:0] main_inst_q,  main_inst_d;
    logic [31:0] main_pc_q,    main_pc_d;
    logic [5:0]  main_fmt_q,   main_fmt_d;
    logic        main_ill_q,   main_ill_d;

    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q,  skid_inst_d;
    logic [31:0] skid_pc_q,    skid_pc_d;
    logic [5:0]  skid_fmt_q,   skid_fmt_d;
    logic        skid_ill_q,   skid_ill_d;

    logic        ready_q, ready_d;

    logic        accept;
    logic        consume;
    logic [6:0]  in_dec;

    assign accept  = i_valid & ready_q;
    assign consume = main_valid_q & i_ready;
    assign in_dec  = decode_fmt(i_inst[6:0]);

    // Next-state for both slots: flush wins, then refill main from skid or
    // input, otherwise park the incoming beat in skid.
    always_comb begin
        main_valid_d = main_valid_q;
        main_inst_d  = main_inst_q;
        main_pc_d    = main_pc_q;
        main_fmt_d   = main_fmt_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_fmt_d   = skid_fmt_q;
        skid_ill_d   = skid_ill_q;

        if (i_flush) begin
            // PC is deliberately left alone so the last seen PC stays visible.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_inst_d  = RESET_INST;
            main_fmt_d   = FMT_I;
            main_ill_d   = 1'b0;
        end else if (!main_valid_q || consume) begin
            if (skid_valid_q) begin
                // ready_q is low here, so no new beat can arrive this cycle.
                main_valid_d = 1'b1;
                main_inst_d  = skid_inst_q;
                main_pc_d    = skid_pc_q;
                main_fmt_d   = skid_fmt_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_inst_d  = i_inst;
                main_pc_d    = i_pc;
                main_fmt_d   = in_dec[5:0];
                main_ill_d   = in_dec[6];
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = i_inst;
            skid_pc_d    = i_pc;
            skid_fmt_d   = in_dec[5:0];
            skid_ill_d   = in_dec[6];
        end

        ready_d = ~skid_valid_d;
    end

    // State registers; reset empties both slots and loads the NOP bundle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_valid_q <= 1'b0;
            main_inst_q  <= RESET_INST;
            main_pc_q    <= RESET_PC;
            main_fmt_q   <= FMT_I;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= RESET_INST;
            skid_pc_q    <= RESET_PC;
            skid_fmt_q   <= FMT_I;
            skid_ill_q   <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_inst_q  <= main_inst_d;
            main_pc_q    <= main_pc_d;
            main_fmt_q   <= main_fmt_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_ill_q   <= skid_ill_d;
            ready_q      <= ready_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_valid   = main_valid_q;
    assign o_inst    = main_inst_q;
    assign o_pc      = main_pc_q;
    assign o_format  = main_fmt_q;
    assign o_illegal = main_ill_q;

endmodule

// File: tb/tb_decode_skid_stage.sv
// Bench for decode_skid_stage: directed scenarios followed by a randomised
// valid/ready stream, all compared against a queue-based reference model.
module tb_decode_skid_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready_dut;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        down_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [5:0]  out_format;
    logic        out_illegal;

    decode_skid_stage dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_flush   (flush),
        .i_valid   (in_valid),
        .o_ready   (out_ready_dut),
        .i_inst    (in_inst),
        .i_pc      (in_pc),
        .o_valid   (out_valid),
        .i_ready   (down_ready),
        .o_inst    (out_inst),
        .o_pc      (out_pc),
        .o_format  (out_format),
        .o_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_out = 0;

    // Reference classification straight from the opcode table; returns
    // {illegal, one-hot format}.
    function automatic logic [6:0] ref_decode(input logic [31:0] inst);
        int idx;
        logic [6:0] op;
        op  = inst[6:0];
        idx = -1;
        if (inst[1:0] == 2'b11) begin
            if (op == 7'h33) idx = 0;
            else if (op == 7'h13 || op == 7'h03 || op == 7'h67 ||
                     op == 7'h73 || op == 7'h0F) idx = 1;
            else if (op == 7'h23) idx = 2;
            else if (op == 7'h63) idx = 3;
            else if (op == 7'h37 || op == 7'h17) idx = 4;
            else if (op == 7'h6F) idx = 5;
        end
        if (idx < 0) return 7'b1_000001;
        return {1'b0, 6'(1 << idx)};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  r[6:0] = 7'h33;
            1:  r[6:0] = 7'h13;
            2:  r[6:0] = 7'h03;
            3:  r[6:0] = 7'h67;
            4:  r[6:0] = 7'h73;
            5:  r[6:0] = 7'h0F;
            6:  r[6:0] = 7'h23;
            7:  r[6:0] = 7'h63;
            8:  r[6:0] = 7'h37;
            9:  r[6:0] = 7'h17;
            10: r[6:0] = 7'h6F;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [6:0] d;
        chk("o_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("o_ready", 32'(out_ready_dut), 32'(exp_q.size() < 2));
        if (exp_q.size() > 0) begin
            d = ref_decode(exp_q[0].inst);
            chk("o_inst", out_inst, exp_q[0].inst);
            chk("o_pc", out_pc, exp_q[0].pc);
            chk("o_format", 32'(out_format), 32'(d[5:0]));
            chk("o_illegal", 32'(out_illegal), 32'(d[6]));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        in_valid   = v;
        in_inst    = inst;
        in_pc      = pc;
        down_ready = rdy;
        flush      = fl;
    endtask

    // One clock: decide transfers from the model's occupancy, advance, check.
    task automatic tick();
        bit   acc, con;
        ent_t e;
        acc = in_valid && (exp_q.size() < 2);
        con = down_ready && (exp_q.size() > 0);
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (con) begin
                exp_q.delete(0);
                n_out++;
            end
            if (acc) begin
                e.inst = in_inst;
                e.pc   = in_pc;
                exp_q.push_back(e);
                n_acc++;
            end
        end
        check_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] stream_inst [6];
    logic [5:0]  stream_fmt  [6];
    int          cycles;
    int          target;

    initial begin
        stream_inst[0] = 32'h00500093; stream_fmt[0] = 6'b000010;
        stream_inst[1] = 32'h00112023; stream_fmt[1] = 6'b000100;
        stream_inst[2] = 32'hFE000EE3; stream_fmt[2] = 6'b001000;
        stream_inst[3] = 32'h123450B7; stream_fmt[3] = 6'b010000;
        stream_inst[4] = 32'h0080006F; stream_fmt[4] = 6'b100000;
        stream_inst[5] = 32'h002081B3; stream_fmt[5] = 6'b000001;

        // Reset state
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(out_ready_dut), 32'd1);
        chk("rst_inst", out_inst, 32'h00000013);
        chk("rst_pc", out_pc, 32'h00000000);
        chk("rst_format", 32'(out_format), 32'b000010);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;

        // Back-to-back stream, one per cycle, one cycle latency
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, stream_inst[i], 32'h100 + 32'(i * 4), 1'b1, 1'b0);
            tick();
            chk("stream_inst", out_inst, stream_inst[i]);
            chk("stream_fmt", 32'(out_format), 32'(stream_fmt[i]));
            chk("stream_ill", 32'(out_illegal), 32'd0);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Backpressure fills main then skid, then drains in order
        drive(1'b1, 32'h00A00113, 32'h200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00B00193, 32'h204, 1'b0, 1'b0);
        tick();
        chk("bp_ready_low", 32'(out_ready_dut), 32'd0);
        chk("bp_main_a", out_inst, 32'h00A00113);
        drive(1'b1, 32'hDEADBEEF, 32'h208, 1'b0, 1'b0);
        tick();
        chk("bp_hold_a", out_inst, 32'h00A00113);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("bp_main_b", out_inst, 32'h00B00193);
        chk("bp_ready_up", 32'(out_ready_dut), 32'd1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Illegal encodings
        drive(1'b1, 32'h0000007F, 32'h300, 1'b1, 1'b0);
        tick();
        chk("ill7f_ill", 32'(out_illegal), 32'd1);
        chk("ill7f_fmt", 32'(out_format), 32'b000001);
        drive(1'b1, 32'h00000000, 32'h304, 1'b1, 1'b0);
        tick();
        chk("ill00_ill", 32'(out_illegal), 32'd1);
        chk("ill00_fmt", 32'(out_format), 32'b000001);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Flush with both slots full and an input presented
        drive(1'b1, 32'h00100093, 32'h400, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00200093, 32'h404, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00300093, 32'h408, 1'b1, 1'b1);
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(out_ready_dut), 32'd1);
        chk("fl_inst", out_inst, 32'h00000013);
        chk("fl_fmt", 32'(out_format), 32'b000010);
        chk("fl_ill", 32'(out_illegal), 32'd0);
        chk("fl_pc_hold", out_pc, 32'h400);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();

        // Flush while main full, skid empty, ready high: the accepted beat is dropped
        drive(1'b1, 32'h00400093, 32'h500, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00500093, 32'h504, 1'b0, 1'b1);
        tick();
        chk("fl2_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("fl2_no_ghost", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges
        drive(1'b1, 32'h00600093, 32'h600, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h00700093, 32'h604, 1'b0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_ready", 32'(out_ready_dut), 32'd1);
        chk("arst_inst", out_inst, 32'h00000013);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h0000A0B7, 32'h700, 1'b1, 1'b0);
        tick();
        chk("arst_new_fmt", 32'(out_format), 32'b010000);
        chk("arst_new_inst", out_inst, 32'h0000A0B7);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Randomised valid/ready over 1000 accepted instructions
        target = n_acc + 1000;
        cycles = 0;
        while (n_acc < target && cycles < 20000) begin
            drive(($urandom_range(0, 3) != 0), rand_inst(), $urandom, ($urandom_range(0, 2) != 0), 1'b0);
            tick();
            cycles++;
        end
        chk("rand_budget", 32'(n_acc >= target), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycles = 0;
        while (exp_q.size() > 0 && cycles < 10) begin
            tick();
            cycles++;
        end
        chk("rand_drain_valid", 32'(out_valid), 32'd0);
        chk("rand_drain_ready", 32'(out_ready_dut), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_skid_stage.md
Name: decode_skid_stage

Overview:
- IF→ID pipeline stage that sits directly upstream of the immediate generator.
- Accepts instruction word + PC from fetch over a valid/ready handshake, classifies the opcode into the one-hot format vector the immediate generator consumes, and presents a registered decode bundle to the ID stage.
- A 2-entry skid buffer sustains full throughput while keeping o_ready a pure register output.
- Supports flush for branch/jump redirect.

Parameters:
- RESET_INST, 32'h00000013, instruction word driven on o_inst under reset/flush (ADDI x0,x0,0 NOP).
- RESET_PC, 32'h00000000, value driven on o_pc under reset.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_flush  input  1  synchronous flush; discards all buffered and incoming instructions.
- i_valid  input  1  fetch presents i_inst/i_pc this cycle.
- o_ready  output  1  stage can accept; registered.
- i_inst  input  32  instruction word from fetch.
- i_pc  input  32  PC of i_inst.
- o_valid  output  1  o_inst/o_pc/o_format/o_illegal are valid.
- i_ready  input  1  ID stage consumes the bundle this cycle.
- o_inst  output  32  buffered instruction word.
- o_pc  output  32  buffered PC.
- o_format  output  6  one-hot format: [0]R [1]I [2]S [3]B [4]U [5]J.
- o_illegal  output  1  opcode not recognised.

Behaviour:
- Reset (i_rst_n low, asynchronous): main_valid=0, skid_valid=0, o_ready=1, o_valid=0, o_inst=RESET_INST, o_pc=RESET_PC, o_format=6'b000010, o_illegal=0. Reset mid-transfer drops everything.
- Storage: main slot (drives outputs) and skid slot. Each slot holds inst, pc, format, illegal, valid.
- Format decode on i_inst[6:0] happens at capture (registered, 1-cycle latency input→output):
  - 0110011 → R
  - 0010011, 0000011, 1100111, 1110011, 0001111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - Anything else, or i_inst[1:0]≠2'b11 → format 6'b000001, o_illegal=1.
- o_format is exactly one-hot whenever o_valid=1.
- Handshake: accept = i_valid & o_ready; consume = o_valid & i_ready. o_ready = ~skid_valid, registered.
- Next-state, no flush:
  - Main empty, or main consumed with skid empty: accepted input → main.
  - Main full and not consumed: accepted input → skid; o_ready falls next cycle.
  - Main consumed and skid full: skid → main, skid clears, o_ready rises next cycle. No accept is possible that cycle, since o_ready=0.
  - Main consumed, nothing accepted, skid empty: main_valid→0.
- Ordering is strictly FIFO; no instruction is duplicated or dropped absent flush.
- Data registers hold their value when the slot is not loaded. o_inst/o_pc stay stable while o_valid & ~i_ready.
- i_flush: next cycle main_valid=0, skid_valid=0, o_ready=1, o_inst=RESET_INST, o_format=I, o_illegal=0; o_pc holds.
  - Input accepted in the flush cycle is discarded.
  - Flush has priority over accept and consume. A consume in the same cycle still counts downstream; the ID stage owns that.
- Back-to-back throughput is 1 instruction/cycle when i_ready is held high.

Test Plan:
- Reset then stream 0x00500093 (ADDI), 0x00112023 (SW), 0xFE000EE3 (BEQ), 0x123450B7 (LUI), 0x0080006F (JAL), 0x002081B3 (ADD) with i_ready=1 → outputs appear 1 cycle later, one per cycle, with o_format 000010, 000100, 001000, 010000, 100000, 000001; o_illegal=0 throughout.
- Backpressure: i_ready=0 while sending A, B → main=A, skid=B, o_ready=0 on cycle after B. Raise i_ready → A, then B on consecutive cycles; o_ready=1 one cycle after B moves to main.
- Illegal: i_inst=0x0000007F and 0x00000000 → o_illegal=1, o_format=000001.
- Flush with both slots full plus an input presented the same cycle → next cycle o_valid=0, o_ready=1, o_inst=0x00000013; the flushed instructions never appear at the output.
- Reset asserted asynchronously mid-stream (between edges) → o_valid drops immediately and o_ready=1. After release, the first new instruction appears with correct format and no stale data.
- Randomised valid/ready toggling over 1000 instructions with scoreboard → in-order, lossless, no duplicates; o_inst stable during any stall.
